// File: rtl/stream_demux_pkg.sv
// Shared types for the 1-to-4 stream demultiplexer: channel index and route FSM states.
package stream_demux_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] chan_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage : stream_demux_pkg

// File: rtl/demux_out_reg.sv
// One-entry registered output stage for a single demux channel.
// A load always wins over a drain, which gives full throughput when the consumer is always ready.
module demux_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      // Data and last keep their old values; only valid drops.
      valid <= 1'b0;
    end
  end

endmodule : demux_out_reg

// File: rtl/stream_demux4.sv
// 1-to-4 streaming demultiplexer: the route is taken from sel_in on a packet's first beat and
// held until its last beat; each channel has a one-entry output stage and a packet counter.
module stream_demux4
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [DATA_W-1:0]        s_data_in,
  input  logic                     s_valid_in,
  input  logic                     s_last_in,
  output logic                     s_ready_out,
  input  logic [1:0]               sel_in,
  output logic [NUM_CH*DATA_W-1:0] m_data_out,
  output logic [NUM_CH-1:0]        m_valid_out,
  output logic [NUM_CH-1:0]        m_last_out,
  input  logic [NUM_CH-1:0]        m_ready_in,
  output logic [NUM_CH*CNT_W-1:0]  pkt_cnt_out,
  output logic                     busy_out,
  output logic [1:0]               route_out
);

  state_e            state_q, state_d;
  chan_t             route_q, route_d;
  chan_t             ch;
  logic              acc;
  logic [NUM_CH-1:0] load;
  logic [CNT_W-1:0]  pkt_cnt_q [NUM_CH];

  // Mid-packet, sel_in is ignored so a packet can never be split across channels.
  assign ch          = (state_q == LOCKED) ? route_q : chan_t'(sel_in);
  assign s_ready_out = !m_valid_out[ch] || m_ready_in[ch];
  assign acc         = s_valid_in && s_ready_out;
  assign busy_out    = (state_q == LOCKED);
  assign route_out   = ch;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    load     = '0;
    load[ch] = acc;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    unique case (state_q)
      IDLE: begin
        // A single-beat packet (last on the first beat) never locks.
        if (acc && !s_last_in) begin
          state_d = LOCKED;
          route_d = chan_t'(sel_in);
        end
      end
      LOCKED: begin
        if (acc && s_last_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the counter array is reset explicitly because software reads it as zero after reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_CH; i++) pkt_cnt_q[i] <= '0;
    end else if (acc && s_last_in) begin
      pkt_cnt_q[ch] <= pkt_cnt_q[ch] + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    demux_out_reg #(
      .DATA_W (DATA_W)
    ) u_out_reg (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .load      (load[i]),
      .load_data (s_data_in),
      .load_last (s_last_in),
      .ready     (m_ready_in[i]),
      .valid     (m_valid_out[i]),
      .data      (m_data_out[i*DATA_W +: DATA_W]),
      .last      (m_last_out[i])
    );

    assign pkt_cnt_out[i*CNT_W +: CNT_W] = pkt_cnt_q[i];
  end

endmodule : stream_demux4

// File: tb/tb_stream_demux4.sv
// Directed bench for stream_demux4; counters are built 4 bits wide so wrap-around is reachable.
module tb_stream_demux4;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic [DATA_W-1:0]   s_data_in;
  logic                s_valid_in;
  logic                s_last_in;
  logic                s_ready_out;
  logic [1:0]          sel_in;
  logic [4*DATA_W-1:0] m_data_out;
  logic [3:0]          m_valid_out;
  logic [3:0]          m_last_out;
  logic [3:0]          m_ready_in;
  logic [4*CNT_W-1:0]  pkt_cnt_out;
  logic                busy_out;
  logic [1:0]          route_out;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  stream_demux4 #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .s_data_in   (s_data_in),
    .s_valid_in  (s_valid_in),
    .s_last_in   (s_last_in),
    .s_ready_out (s_ready_out),
    .sel_in      (sel_in),
    .m_data_out  (m_data_out),
    .m_valid_out (m_valid_out),
    .m_last_out  (m_last_out),
    .m_ready_in  (m_ready_in),
    .pkt_cnt_out (pkt_cnt_out),
    .busy_out    (busy_out),
    .route_out   (route_out)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic [1:0] s);
    s_valid_in = v;
    s_data_in  = d;
    s_last_in  = l;
    sel_in     = s;
  endtask

  function automatic logic [7:0] ch_data(input int c);
    return m_data_out[c*DATA_W +: DATA_W];
  endfunction

  function automatic logic [3:0] ch_cnt(input int c);
    return pkt_cnt_out[c*CNT_W +: CNT_W];
  endfunction

  logic [7:0] t_dat [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [1:0] t_sel [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
  logic       t_lst [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_in     = 1'b1;
    m_ready_in = 4'hF;
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    step();
    step();
    rst_in = 1'b0;
    #1;
    check("rst_valid", 32'(m_valid_out), 32'h0);
    check("rst_last",  32'(m_last_out),  32'h0);
    check("rst_data",  m_data_out,       32'h0);
    check("rst_cnt",   32'(pkt_cnt_out), 32'h0);
    check("rst_busy",  32'(busy_out),    32'h0);
    check("rst_ready", 32'(s_ready_out), 32'h1);

    // Single-beat packet to ch2.
    drive(1'b1, 8'hA5, 1'b1, 2'd2);
    step();
    check("single_valid", 32'(m_valid_out), 32'h4);
    check("single_data",  32'(ch_data(2)),  32'hA5);
    check("single_last",  32'(m_last_out),  32'h4);
    check("single_cnt2",  32'(ch_cnt(2)),   32'h1);
    check("single_busy",  32'(busy_out),    32'h0);
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    step();
    check("single_drain", 32'(m_valid_out), 32'h0);

    // 3-beat packet to ch1; sel_in moves to 3 after the first beat and must be ignored.
    drive(1'b1, 8'h11, 1'b0, 2'd1);
    step();
    check("pkt_b1_valid", 32'(m_valid_out), 32'h2);
    check("pkt_b1_data",  32'(ch_data(1)),  32'h11);
    check("pkt_b1_busy",  32'(busy_out),    32'h1);
    drive(1'b1, 8'h22, 1'b0, 2'd3);
    #1;
    check("pkt_route_lock", 32'(route_out), 32'h1);
    step();
    check("pkt_b2_valid", 32'(m_valid_out), 32'h2);
    check("pkt_b2_data",  32'(ch_data(1)),  32'h22);
    check("pkt_b2_busy",  32'(busy_out),    32'h1);
    drive(1'b1, 8'h33, 1'b1, 2'd3);
    step();
    check("pkt_b3_valid", 32'(m_valid_out), 32'h2);
    check("pkt_b3_data",  32'(ch_data(1)),  32'h33);
    check("pkt_b3_last",  32'(m_last_out[1]), 32'h1);
    check("pkt_b3_busy",  32'(busy_out),    32'h0);
    check("pkt_cnt1",     32'(ch_cnt(1)),   32'h1);
    check("pkt_cnt3",     32'(ch_cnt(3)),   32'h0);
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    step();

    // Backpressure on ch0, then release with no bubble.
    m_ready_in = 4'b1110;
    drive(1'b1, 8'h5A, 1'b1, 2'd0);
    step();
    check("bp_first", 32'(ch_data(0)), 32'h5A);
    drive(1'b1, 8'h5B, 1'b1, 2'd0);
    #1;
    check("bp_ready_low", 32'(s_ready_out), 32'h0);
    step();
    check("bp_hold_data",  32'(ch_data(0)),    32'h5A);
    check("bp_hold_valid", 32'(m_valid_out[0]), 32'h1);
    check("bp_hold_cnt0",  32'(ch_cnt(0)),     32'h1);
    m_ready_in = 4'hF;
    #1;
    check("bp_ready_high", 32'(s_ready_out), 32'h1);
    step();
    check("bp_next_data",  32'(ch_data(0)),    32'h5B);
    check("bp_next_valid", 32'(m_valid_out[0]), 32'h1);
    check("bp_cnt0",       32'(ch_cnt(0)),     32'h2);
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    step();

    // ch2 stalls while ch0 and ch1 stream at one beat per cycle.
    m_ready_in = 4'b1011;
    drive(1'b1, 8'hC3, 1'b1, 2'd2);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, t_dat[k], t_lst[k], t_sel[k]);
      #1;
      check($sformatf("ind_ready_%0d", k), 32'(s_ready_out), 32'h1);
      step();
      check($sformatf("ind_data_%0d", k),  32'(ch_data(int'(t_sel[k]))), 32'(t_dat[k]));
      check($sformatf("ind_ch2_%0d", k),   32'(ch_data(2)), 32'hC3);
      check($sformatf("ind_v2_%0d", k),    32'(m_valid_out[2]), 32'h1);
    end
    check("ind_cnt0", 32'(ch_cnt(0)), 32'h3);
    check("ind_cnt1", 32'(ch_cnt(1)), 32'h2);
    check("ind_cnt2", 32'(ch_cnt(2)), 32'h2);
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    m_ready_in = 4'hF;
    step();
    check("ind_drain", 32'(m_valid_out), 32'h0);

    // 17 single-beat packets to ch3 wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i), 1'b1, 2'd3);
      step();
      if (i == 15) check("wrap_at16", 32'(ch_cnt(3)), 32'h0);
    end
    check("wrap_cnt3", 32'(ch_cnt(3)), 32'h1);
    check("wrap_data", 32'(ch_data(3)), 32'h10);
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    step();

    // Reset in the middle of a packet with ch1 holding a beat.
    m_ready_in = 4'b1101;
    drive(1'b1, 8'h77, 1'b0, 2'd1);
    step();
    check("mid_busy",  32'(busy_out),    32'h1);
    check("mid_valid", 32'(m_valid_out), 32'h2);
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("mid_rst_valid", 32'(m_valid_out), 32'h0);
    check("mid_rst_busy",  32'(busy_out),    32'h0);
    check("mid_rst_cnt",   32'(pkt_cnt_out), 32'h0);
    check("mid_rst_data",  m_data_out,       32'h0);
    m_ready_in = 4'hF;
    drive(1'b1, 8'h88, 1'b1, 2'd2);
    #1;
    check("post_route", 32'(route_out), 32'h2);
    step();
    check("post_valid", 32'(m_valid_out), 32'h4);
    check("post_data",  32'(ch_data(2)),  32'h88);
    check("post_cnt2",  32'(ch_cnt(2)),   32'h1);
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stream_demux4
